// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions, also imported by the VGA scan-out reader.
// The FB_DOUBLE_BUF_EN build option is handled in fb_pixel_writer.
package fb_pkg;

    localparam int unsigned H_RES  = 400;
    localparam int unsigned V_RES  = 300;
    localparam int unsigned ADDR_W = 17;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } fb_state_t;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Raster-ordered pixel stream (valid/ready with start-of-frame) into the frame-buffer writer.
interface fb_pixel_writer_if;

    logic           s_valid;
    logic           s_ready;
    logic           s_sof;
    fb_pkg::pixel_t s_data;

    modport master (
        output s_valid,
        output s_sof,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_sof,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/fb_coord_counter.sv
// Raster x/y position and running linear address of the next pixel to be written.
// Priority: clear over restart over inc; restart positions the counters just after pixel (0,0).
module fb_coord_counter #(
    parameter int unsigned HRes  = 400,
    parameter int unsigned VRes  = 300,
    parameter int unsigned AddrW = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    input  logic             restart,
    output logic [AddrW-1:0] addr,
    output logic             last_pixel
);

    localparam int unsigned XW = (HRes > 1) ? $clog2(HRes) : 1;
    localparam int unsigned YW = (VRes > 1) ? $clog2(VRes) : 1;

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic             eol;

    assign eol        = (x_q == XW'(HRes - 1));
    assign last_pixel = eol && (y_q == YW'(VRes - 1));
    assign addr       = addr_q;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (restart) begin
            x_d    = XW'(1);
            y_d    = '0;
            addr_d = AddrW'(1);
        end else if (inc) begin
            // Address runs linearly, so a line wrap needs no multiply.
            if (eol) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            addr_d = addr_q + AddrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Write side of the RGB222 frame buffer: turns the pixel stream into registered write strobes.
// Define FB_DOUBLE_BUF_EN for two banks (bank bit on the address MSB plus a front_bank output).
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int unsigned HRes  = H_RES,
    parameter int unsigned VRes  = V_RES,
    parameter int unsigned AddrW = ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    fb_pixel_writer_if.slave pix,
    output logic             wr_en,
`ifdef FB_DOUBLE_BUF_EN
    output logic [AddrW:0]   wr_addr,
`else
    output logic [AddrW-1:0] wr_addr,
`endif
    output logic [5:0]       wr_data,
    output logic             frame_done,
    output logic             frame_abort
`ifdef FB_DOUBLE_BUF_EN
    ,
    output logic             front_bank
`endif
);

    fb_state_t state_q, state_d;

    logic                     ready_q, ready_d;
    logic                     wr_en_q, wr_en_d;
    logic [$bits(wr_addr)-1:0] wr_addr_q, wr_addr_d;
    logic [5:0]               wr_data_q, wr_data_d;
    logic                     done_q, done_d;
    logic                     abort_q, abort_d;

    logic                     accept;
    logic                     cnt_inc, cnt_clear, cnt_restart;
    logic [AddrW-1:0]         cnt_addr;
    logic                     cnt_last;
    logic [AddrW-1:0]         sel_addr;
    logic [$bits(wr_addr)-1:0] full_addr;

    fb_coord_counter #(
        .HRes (HRes),
        .VRes (VRes),
        .AddrW(AddrW)
    ) u_coord (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (cnt_inc),
        .clear     (cnt_clear),
        .restart   (cnt_restart),
        .addr      (cnt_addr),
        .last_pixel(cnt_last)
    );

    assign accept   = pix.s_valid & pix.s_ready;
    // A start-of-frame pixel always lands on address 0, whatever the counter holds.
    assign sel_addr = pix.s_sof ? '0 : cnt_addr;

`ifdef FB_DOUBLE_BUF_EN
    logic back_bank_q;
    logic front_bank_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            back_bank_q  <= 1'b0;
            front_bank_q <= 1'b1;
        end else if (done_d) begin
            back_bank_q  <= ~back_bank_q;
            front_bank_q <= back_bank_q;
        end
    end

    assign full_addr  = {back_bank_q, sel_addr};
    assign front_bank = front_bank_q;
`else
    assign full_addr = sel_addr;
`endif

    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clear   = 1'b0;
        cnt_restart = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Pixels without sof are dropped until a frame starts.
                if (accept && pix.s_sof) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = full_addr;
                    wr_data_d   = pix.s_data;
                    cnt_restart = 1'b1;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = full_addr;
                    wr_data_d = pix.s_data;
                    if (pix.s_sof) begin
                        abort_d     = 1'b1;
                        cnt_restart = 1'b1;
                    end else if (cnt_last) begin
                        done_d    = 1'b1;
                        cnt_clear = 1'b1;
                        state_d   = StDone;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d != StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign pix.s_ready = ready_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer using a 400x3 buffer so frames stay short.
module tb_fb_pixel_writer;
    import fb_pkg::*;

    localparam int unsigned HRES = 400;
    localparam int unsigned VRES = 3;
    localparam int unsigned NPIX = HRES * VRES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_pixel_writer_if pix();

    logic       wr_en;
`ifdef FB_DOUBLE_BUF_EN
    logic [ADDR_W:0]   wr_addr;
    logic              front_bank;
`else
    logic [ADDR_W-1:0] wr_addr;
`endif
    logic [5:0] wr_data;
    logic       frame_done;
    logic       frame_abort;

    fb_pixel_writer #(
        .HRes (HRES),
        .VRes (VRES),
        .AddrW(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix        (pix),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_abort(frame_abort)
`ifdef FB_DOUBLE_BUF_EN
        ,
        .front_bank (front_bank)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 writing, 2 done
    int m_state = 0;
    int m_idx = 0;
    bit m_ready = 1'b0;
    bit m_back = 1'b0;
    bit m_front = 1'b1;

    int n_wr, n_done, n_abort, n_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_wr = 0; n_done = 0; n_abort = 0; n_acc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pix.s_valid = 1'b1;
        pix.s_sof = 1'b0;
        pix.s_data = 6'h3F;
        @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'(0));
        check("rst_wr_addr", 32'(wr_addr), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_done", 32'(frame_done), 32'(0));
        check("rst_abort", 32'(frame_abort), 32'(0));
        check("rst_ready", 32'(pix.s_ready), 32'(0));
`ifdef FB_DOUBLE_BUF_EN
        check("rst_front", 32'(front_bank), 32'(1));
`endif
        m_state = 0; m_idx = 0; m_ready = 1'b0; m_back = 1'b0; m_front = 1'b1;
    endtask

    task automatic step(input bit v, input bit sof, input logic [5:0] d, output bit acc);
        bit exp_en, exp_done, exp_abort;
        logic [31:0] exp_addr;
        exp_en = 0; exp_done = 0; exp_abort = 0; exp_addr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pix.s_valid = v;
        pix.s_sof = sof;
        pix.s_data = d;
        check("s_ready", 32'(pix.s_ready), 32'(m_ready));
        acc = v && m_ready;
        case (m_state)
            0: if (acc && sof) begin
                exp_en = 1; exp_addr = 0; m_idx = 1; m_state = 1;
            end
            1: if (acc) begin
                exp_en = 1;
                if (sof) begin
                    exp_abort = 1; exp_addr = 0; m_idx = 1;
                end else begin
                    exp_addr = 32'(m_idx);
                    if (m_idx == NPIX - 1) begin
                        exp_done = 1; m_state = 2; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            default: m_state = 0;
        endcase
`ifdef FB_DOUBLE_BUF_EN
        if (exp_en) exp_addr = exp_addr | (32'(m_back) << ADDR_W);
        if (exp_done) begin
            m_front = m_back;
            m_back = ~m_back;
        end
`endif
        m_ready = (m_state != 2);
        @(posedge clk);
        #1;
        check("wr_en", 32'(wr_en), 32'(exp_en));
        if (exp_en) begin
            check("wr_addr", 32'(wr_addr), exp_addr);
            check("wr_data", 32'(wr_data), 32'(d));
        end
        check("frame_done", 32'(frame_done), 32'(exp_done));
        check("frame_abort", 32'(frame_abort), 32'(exp_abort));
`ifdef FB_DOUBLE_BUF_EN
        check("front_bank", 32'(front_bank), 32'(m_front));
`endif
        if (wr_en) n_wr++;
        if (frame_done) n_done++;
        if (frame_abort) n_abort++;
        if (acc) n_acc++;
    endtask

    // Sends n pixels (sof on the first and at abort_at); data is the in-frame index [5:0].
    task automatic run_frame(input int n, input int abort_at, input bit rnd);
        int sent = 0;
        int guard = 0;
        bit v, sof, acc;
        int pos;
        while (sent < n && guard < 4 * n + 16) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sof = (sent == 0) || (sent == abort_at);
            pos = (abort_at >= 0 && sent >= abort_at) ? sent - abort_at : sent;
            step(v, sof, pos[5:0], acc);
            if (acc) sent++;
            guard++;
        end
        check("frame_sent", 32'(sent), 32'(n));
    endtask

    initial begin
        bit acc;
        pix.s_valid = 1'b0;
        pix.s_sof = 1'b0;
        pix.s_data = '0;
        do_reset();
        do_reset();
        clear_counts();
        step(1'b0, 1'b0, 6'h00, acc);

        // Non-sof pixels while idle are dropped
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 6'h3F, acc);
        check("t2_no_writes", 32'(n_wr), 32'(0));

        // Full frame, valid always high
        clear_counts();
        run_frame(NPIX, -1, 1'b0);
        step(1'b0, 1'b0, 6'h00, acc);
        step(1'b0, 1'b0, 6'h00, acc);
        check("t1_writes", 32'(n_wr), 32'(NPIX));
        check("t1_done", 32'(n_done), 32'(1));
        check("t1_abort", 32'(n_abort), 32'(0));
`ifdef FB_DOUBLE_BUF_EN
        check("t6_front_f1", 32'(front_bank), 32'(0));
`endif

        // sof at pixel 1000 (x=200,y=2) aborts and restarts
        clear_counts();
        run_frame(1000 + NPIX, 1000, 1'b0);
        step(1'b0, 1'b0, 6'h00, acc);
        step(1'b0, 1'b0, 6'h00, acc);
        check("t3_writes", 32'(n_wr), 32'(1000 + NPIX));
        check("t3_abort", 32'(n_abort), 32'(1));
        check("t3_done", 32'(n_done), 32'(1));
`ifdef FB_DOUBLE_BUF_EN
        check("t6_front_f2", 32'(front_bank), 32'(1));
`endif

        // Random valid gaps
        clear_counts();
        run_frame(NPIX, -1, 1'b1);
        step(1'b0, 1'b0, 6'h00, acc);
        step(1'b0, 1'b0, 6'h00, acc);
        check("t4_wr_vs_acc", 32'(n_wr), 32'(n_acc));
        check("t4_done", 32'(n_done), 32'(1));

        // Reset mid-frame, then a fresh frame
        clear_counts();
        run_frame(500, -1, 1'b0);
        do_reset();
        step(1'b0, 1'b0, 6'h00, acc);
        check("t5_no_done", 32'(n_done), 32'(0));
        check("t5_no_abort", 32'(n_abort), 32'(0));
        clear_counts();
        run_frame(NPIX, -1, 1'b0);
        step(1'b0, 1'b0, 6'h00, acc);
        check("t5_done", 32'(n_done), 32'(1));
        check("t5_writes", 32'(n_wr), 32'(NPIX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
